// File: rtl/mem_access_stage_if.sv
// Bundle of the execute-side, data-memory-bus and writeback handshake signals
// seen by the memory-access stage. master = the stage itself, slave = its surroundings.
interface mem_access_stage_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_res;
    logic [31:0] ex_store_data;
    logic [3:0]  ex_mem_op;
    logic [4:0]  ex_rd;
    logic        ex_wb_en;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_en;
    logic        wb_fault;

    modport master (
        input  ex_valid, ex_alu_res, ex_store_data, ex_mem_op, ex_rd, ex_wb_en,
        output ex_ready,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata,
        output wb_valid, wb_data, wb_rd, wb_en, wb_fault,
        input  wb_ready
    );

    modport slave (
        output ex_valid, ex_alu_res, ex_store_data, ex_mem_op, ex_rd, ex_wb_en,
        input  ex_ready,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata,
        input  wb_valid, wb_data, wb_rd, wb_en, wb_fault,
        output wb_ready
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues load/store on a req/ack data bus, lane-aligns
// store data, extends load data, and reports misalignment/timeout faults to writeback.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_access_stage_if.master bus
);

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_e;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LH   = 4'd2,
        OP_LW   = 4'd3,
        OP_LBU  = 4'd4,
        OP_LHU  = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic        ld_en_q, ld_en_d;

    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_en_q, wb_en_d;
    logic        wb_fault_q, wb_fault_d;

    logic        ex_ready;
    logic        accept;
    logic [2:0]  acc_bytes;
    logic        is_store;
    logic        is_mem;
    logic        misalign;
    logic [1:0]  lane;
    logic [3:0]  dec_be;
    logic [31:0] dec_wdata;
    logic        to_hit;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    assign ex_ready = (state_q == S_IDLE) & (~wb_valid_q | bus.wb_ready);
    assign accept   = bus.ex_valid & ex_ready;
    assign lane     = bus.ex_alu_res[1:0];
    assign to_hit   = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

    // Decode access size, direction, alignment and lane mapping of the incoming op.
    always_comb begin
        acc_bytes = 3'd0;
        is_store  = 1'b0;
        case (bus.ex_mem_op)
            OP_LB, OP_LBU: acc_bytes = 3'd1;
            OP_LH, OP_LHU: acc_bytes = 3'd2;
            OP_LW:         acc_bytes = 3'd4;
            OP_SB: begin
                acc_bytes = 3'd1;
                is_store  = 1'b1;
            end
            OP_SH: begin
                acc_bytes = 3'd2;
                is_store  = 1'b1;
            end
            OP_SW: begin
                acc_bytes = 3'd4;
                is_store  = 1'b1;
            end
            default: acc_bytes = 3'd0;
        endcase

        is_mem   = (acc_bytes != 3'd0);
        misalign = ((acc_bytes == 3'd2) && lane[0]) ||
                   ((acc_bytes == 3'd4) && (lane != 2'b00));

        case (acc_bytes)
            3'd1:    dec_be = 4'b0001 << lane;
            3'd2:    dec_be = lane[1] ? 4'b1100 : 4'b0011;
            3'd4:    dec_be = 4'b1111;
            default: dec_be = '0;
        endcase

        dec_wdata = '0;
        if (is_store) begin
            case (acc_bytes)
                3'd1:    dec_wdata = {4{bus.ex_store_data[7:0]}};
                3'd2:    dec_wdata = {2{bus.ex_store_data[15:0]}};
                default: dec_wdata = bus.ex_store_data;
            endcase
        end
    end

    always_comb begin
        ld_byte = bus.mem_rdata[{off_q, 3'b000} +: 8];
        ld_half = bus.mem_rdata[{off_q[1], 4'b0000} +: 16];
        case (op_q)
            OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_val = {24'b0, ld_byte};
            OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_val = {16'b0, ld_half};
            OP_LW:   ld_val = bus.mem_rdata;
            default: ld_val = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        off_d      = off_q;
        rd_d       = rd_q;
        ld_en_d    = ld_en_q;
        wb_valid_d = wb_valid_q & ~bus.wb_ready;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_en_d    = wb_en_q;
        wb_fault_d = wb_fault_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_mem && !misalign) begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
                        we_d    = is_store;
                        addr_d  = {bus.ex_alu_res[31:2], 2'b00};
                        be_d    = dec_be;
                        wdata_d = dec_wdata;
                        cnt_d   = '0;
                        op_d    = bus.ex_mem_op;
                        off_d   = lane;
                        rd_d    = bus.ex_rd;
                        ld_en_d = bus.ex_wb_en & (bus.ex_rd != 5'd0) & ~is_store;
                    end else begin
                        // Non-memory ops and misaligned accesses retire straight to writeback.
                        wb_valid_d = 1'b1;
                        wb_rd_d    = bus.ex_rd;
                        wb_fault_d = misalign;
                        wb_data_d  = misalign ? '0 : bus.ex_alu_res;
                        wb_en_d    = ~misalign & bus.ex_wb_en & (bus.ex_rd != 5'd0);
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_ack) begin
                    state_d    = S_IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_fault_d = 1'b0;
                    wb_data_d  = ld_val;
                    wb_en_d    = ld_en_q;
                end else if (to_hit) begin
                    state_d    = S_IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_fault_d = 1'b1;
                    wb_data_d  = '0;
                    wb_en_d    = 1'b0;
                end else if (TIMEOUT_CYC != 0) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            op_q       <= '0;
            off_q      <= '0;
            rd_q       <= '0;
            ld_en_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_en_q    <= 1'b0;
            wb_fault_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
            ld_en_q    <= ld_en_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_en_q    <= wb_en_d;
            wb_fault_q <= wb_fault_d;
        end
    end

    assign bus.ex_ready  = ex_ready;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_en     = wb_en_q;
    assign bus.wb_fault  = wb_fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, multi-cycle corner
// sequences, and randomized ops scored against an arithmetic reference model.
module tb_mem_access_stage;

    localparam int TO = 4;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        wben;
        int          dly;
        int          stall;
        logic        x_req;
        logic        x_we;
        logic [31:0] x_addr;
        logic [3:0]  x_be;
        logic [31:0] x_wdata;
        logic [31:0] x_data;
        logic        x_en;
        logic        x_fault;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_access_stage_if bus ();

    mem_access_stage #(.TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] sdata, input logic [31:0] rdata,
                                input logic [4:0] rd, input logic wben, input int dly,
                                input int stall, input logic x_req, input logic x_we,
                                input logic [3:0] x_be, input logic [31:0] x_wdata,
                                input logic [31:0] x_data, input logic x_en,
                                input logic x_fault);
        vec_t v;
        v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
        v.rd = rd; v.wben = wben; v.dly = dly; v.stall = stall;
        v.x_req = x_req; v.x_we = x_we; v.x_addr = {addr[31:2], 2'b00};
        v.x_be = x_be; v.x_wdata = x_wdata; v.x_data = x_data;
        v.x_en = x_en; v.x_fault = x_fault;
        return v;
    endfunction

    // Reference model: derives bus and writeback expectations from access size and offset.
    function automatic vec_t model(input vec_t v);
        vec_t            r;
        int unsigned     sz;
        int unsigned     k;
        bit              sgn;
        bit              st;
        longint unsigned mask;
        longint unsigned val;
        r = v;
        k = v.addr[1:0];
        sz = 0; sgn = 0; st = 0;
        case (v.op)
            4'd1: begin sz = 1; sgn = 1; end
            4'd2: begin sz = 2; sgn = 1; end
            4'd3: sz = 4;
            4'd4: sz = 1;
            4'd5: sz = 2;
            4'd6: begin sz = 1; st = 1; end
            4'd7: begin sz = 2; st = 1; end
            4'd8: begin sz = 4; st = 1; end
            default: sz = 0;
        endcase
        r.x_req = 0; r.x_we = 0; r.x_addr = v.addr & 32'hFFFF_FFFC; r.x_be = 0;
        r.x_wdata = 0; r.x_data = 0; r.x_en = 0; r.x_fault = 0;
        if (sz == 0) begin
            r.x_data = v.addr;
            r.x_en = v.wben && (v.rd != 0);
            return r;
        end
        if ((v.addr % sz) != 0) begin
            r.x_fault = 1;
            return r;
        end
        mask = (64'd1 << (8 * sz)) - 64'd1;
        r.x_req = 1;
        r.x_we = st;
        r.x_be = 4'(((1 << sz) - 1) << k);
        if (st)
            r.x_wdata = 32'(({32'b0, v.sdata} & mask) *
                        (sz == 1 ? 64'h0101_0101 : (sz == 2 ? 64'h0001_0001 : 64'h1)));
        if (v.dly >= TO) begin
            r.x_fault = 1;
            return r;
        end
        if (st) return r;
        val = ({32'b0, v.rdata} >> (8 * k)) & mask;
        if (sgn && val >= (mask + 64'd1) / 2) val = val | ~mask;
        r.x_data = 32'(val);
        r.x_en = v.wben && (v.rd != 0);
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input string nm);
        int n;
        @(negedge clk);
        bus.ex_valid      = 1'b1;
        bus.ex_mem_op     = v.op;
        bus.ex_alu_res    = v.addr;
        bus.ex_store_data = v.sdata;
        bus.ex_rd         = v.rd;
        bus.ex_wb_en      = v.wben;
        bus.mem_rdata     = v.rdata;
        bus.wb_ready      = (v.stall == 0);
        n = 0;
        while (!bus.ex_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_ex_ready"}, {31'b0, bus.ex_ready}, 32'd1);
        if (!bus.ex_ready) begin
            bus.ex_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.ex_valid = 1'b0;
        if (v.x_req) begin
            for (int k = 0; k < TO; k++) begin
                chk({nm, "_mem_req"}, {31'b0, bus.mem_req}, 32'd1);
                chk({nm, "_mem_addr"}, bus.mem_addr, v.x_addr);
                chk({nm, "_mem_be"}, {28'b0, bus.mem_be}, {28'b0, v.x_be});
                chk({nm, "_mem_we"}, {31'b0, bus.mem_we}, {31'b0, v.x_we});
                if (v.x_we) chk({nm, "_mem_wdata"}, bus.mem_wdata, v.x_wdata);
                if (k == v.dly) bus.mem_ack = 1'b1;
                @(negedge clk);
                bus.mem_ack = 1'b0;
                if (k == v.dly) break;
            end
        end
        chk({nm, "_req_low"}, {31'b0, bus.mem_req}, 32'd0);
        chk({nm, "_wb_valid"}, {31'b0, bus.wb_valid}, 32'd1);
        chk({nm, "_wb_data"}, bus.wb_data, v.x_data);
        chk({nm, "_wb_rd"}, {27'b0, bus.wb_rd}, {27'b0, v.rd});
        chk({nm, "_wb_en"}, {31'b0, bus.wb_en}, {31'b0, v.x_en});
        chk({nm, "_wb_fault"}, {31'b0, bus.wb_fault}, {31'b0, v.x_fault});
        for (int s = 0; s < v.stall; s++) begin
            @(negedge clk);
            chk({nm, "_stall_ex_ready"}, {31'b0, bus.ex_ready}, 32'd0);
            chk({nm, "_stall_valid"}, {31'b0, bus.wb_valid}, 32'd1);
            chk({nm, "_stall_data"}, bus.wb_data, v.x_data);
            chk({nm, "_stall_fault"}, {31'b0, bus.wb_fault}, {31'b0, v.x_fault});
        end
        bus.wb_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_wb_drained"}, {31'b0, bus.wb_valid}, 32'd0);
    endtask

    vec_t tbl[14];

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;
        bus.ex_valid = 0; bus.ex_alu_res = 0; bus.ex_store_data = 0; bus.ex_mem_op = 0;
        bus.ex_rd = 0; bus.ex_wb_en = 0; bus.mem_ack = 0; bus.mem_rdata = 0; bus.wb_ready = 1;

        //          op     addr          sdata         rdata         rd wb dly st req we be       wdata         data          en flt
        tbl[0]  = mk(4'd0,  32'h0000_1234, 32'h0,        32'h0,        5,  1, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h0000_1234, 1, 0);
        tbl[1]  = mk(4'd1,  32'h0000_0103, 32'h0,        32'h80FF_FF00, 3, 1, 2, 0, 1, 0, 4'b1000, 32'h0,        32'hFFFF_FF80, 1, 0);
        tbl[2]  = mk(4'd7,  32'h0000_0202, 32'hABCD_5678, 32'h0,        9,  1, 0, 0, 1, 1, 4'b1100, 32'h5678_5678, 32'h0,        0, 0);
        tbl[3]  = mk(4'd3,  32'h0000_0301, 32'h0,        32'h0,        6,  1, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 1);
        tbl[4]  = mk(4'd5,  32'h0000_0044, 32'h0,        32'h1234_5678, 8, 1, 9, 0, 1, 0, 4'b0011, 32'h0,        32'h0,        0, 1);
        tbl[5]  = mk(4'd3,  32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 7, 1, 3, 0, 1, 0, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1, 0);
        tbl[6]  = mk(4'd4,  32'h0000_0021, 32'h0,        32'h0000_9A00, 2, 1, 1, 0, 1, 0, 4'b0010, 32'h0,        32'h0000_009A, 1, 0);
        tbl[7]  = mk(4'd2,  32'h0000_0032, 32'h0,        32'h8001_7FFF, 2, 1, 0, 1, 1, 0, 4'b1100, 32'h0,        32'hFFFF_8001, 1, 0);
        tbl[8]  = mk(4'd6,  32'h0000_0013, 32'h1234_56C3, 32'h0,        1,  1, 1, 0, 1, 1, 4'b1000, 32'hC3C3_C3C3, 32'h0,        0, 0);
        tbl[9]  = mk(4'd8,  32'h0000_0008, 32'hCAFE_F00D, 32'h0,        1,  1, 0, 0, 1, 1, 4'b1111, 32'hCAFE_F00D, 32'h0,        0, 0);
        tbl[10] = mk(4'd0,  32'h0000_0055, 32'h0,        32'h0,        0,  1, 0, 5, 0, 0, 4'b0000, 32'h0,        32'h0000_0055, 0, 0);
        tbl[11] = mk(4'd12, 32'hFFFF_0000, 32'h0,        32'h0,        31, 1, 0, 0, 0, 0, 4'b0000, 32'h0,        32'hFFFF_0000, 1, 0);
        tbl[12] = mk(4'd7,  32'h0000_0201, 32'h1111_2222, 32'h0,        4,  1, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 1);
        tbl[13] = mk(4'd1,  32'h0000_0000, 32'h0,        32'h0000_007F, 4, 0, 0, 0, 1, 0, 4'b0001, 32'h0,        32'h0000_007F, 0, 0);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_be", {28'b0, bus.mem_be}, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_wb_rd", {27'b0, bus.wb_rd}, 32'd0);
        chk("rst_wb_en", {31'b0, bus.wb_en}, 32'd0);
        chk("rst_wb_fault", {31'b0, bus.wb_fault}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ex_ready", {31'b0, bus.ex_ready}, 32'd1);

        for (int i = 0; i < 14; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back NONE ops at full throughput.
        @(negedge clk);
        bus.wb_ready = 1'b1;
        bus.ex_mem_op = 4'd0;
        bus.ex_wb_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.ex_valid = 1'b1;
            bus.ex_alu_res = 32'hA000_0000 + 32'(i);
            bus.ex_rd = 5'(i + 1);
            chk("b2b_ex_ready", {31'b0, bus.ex_ready}, 32'd1);
            @(negedge clk);
            chk("b2b_wb_valid", {31'b0, bus.wb_valid}, 32'd1);
            chk("b2b_wb_data", bus.wb_data, 32'hA000_0000 + 32'(i));
            chk("b2b_wb_rd", {27'b0, bus.wb_rd}, 32'(i + 1));
        end
        bus.ex_valid = 1'b0;
        @(negedge clk);
        chk("b2b_drained", {31'b0, bus.wb_valid}, 32'd0);

        // Stray ack while idle must be ignored.
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("stray_ack_valid", {31'b0, bus.wb_valid}, 32'd0);
        chk("stray_ack_req", {31'b0, bus.mem_req}, 32'd0);

        // Reset asserted while a request is outstanding.
        bus.ex_valid = 1'b1;
        bus.ex_mem_op = 4'd3;
        bus.ex_alu_res = 32'h0000_0040;
        bus.ex_rd = 5'd10;
        @(negedge clk);
        bus.ex_valid = 1'b0;
        chk("rstreq_req_high", {31'b0, bus.mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rstreq_req_async_low", {31'b0, bus.mem_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rstreq_no_wb", {31'b0, bus.wb_valid}, 32'd0);
            chk("rstreq_no_req", {31'b0, bus.mem_req}, 32'd0);
            @(negedge clk);
        end

        for (int i = 0; i < 60; i++) begin
            int sel;
            sel = $urandom_range(0, 10);
            v.op = (sel > 8) ? 4'($urandom_range(9, 15)) : 4'(sel);
            v.addr = $urandom;
            if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
            v.sdata = $urandom;
            v.rdata = $urandom;
            v.rd = 5'($urandom);
            v.wben = 1'($urandom);
            v.dly = $urandom_range(0, TO + 1);
            v.stall = $urandom_range(0, 2);
            v = model(v);
            run_vec(v, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
